nn_layer_seq: RTL and testbench
===============================

NN_LAYER_SEQ -- requirements
Module: nn_layer_seq

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: ADDR_WIDTH 16 address width; L1_IN 401 layer-1 activations incl. bias; L1_N 25 hidden neurons; L2_N 10 output neurons; LANES 1 weights per memory word; ADDR_BASE_A 0, ADDR_BASE_W 0, ADDR_BASE_LUT_L1 0, ADDR_BASE_LUT_L2 0 region bases.
REQ-002 Derived: W1 = ceil(L1_N/LANES), W2 = ceil(L2_N/LANES), L2_IN = L1_N+1.
REQ-003 Ports (name direction width meaning): clk in 1 clock; rst in 1 reset, synchronous, active-high; start in 1 begin inference; abort in 1 cancel run; done_ack in 1 release DONE; busy out 1 run active; done out 1 result ready; mem_addr out ADDR_WIDTH read address; arg_zero in 1 loaded activation is zero; lut_idx in ADDR_WIDTH sigmoid LUT index from MAC; lut_pos out ADDR_WIDTH activation/result slot; lut_sel out 1 0=L1 LUT, 1=L2 LUT; r_sh_en out 4 shift enables {res,w2,w1,a}; mac_en out 2 {L2,L1}; mac_clr out 2 {L2,L1}.

Function
REQ-004 States SHALL be IDLE, L1_LD_A, L1_LD_W, L1_MAC, L2_LD_W, L2_MAC, LUT_SAVE, DONE.
REQ-005 IDLE: mac_clr=2'b11; start=1 and abort=0 -> L1_LD_A with all counters and offsets zeroed; otherwise stay.
REQ-006 L1_LD_A (1 cycle): mem_addr=ADDR_BASE_A+a_idx, r_sh_en=4'b0001, a_idx++, -> L1_LD_W.
REQ-007 L1_LD_W: W1 cycles, beat b: mem_addr=ADDR_BASE_W+w_off, r_sh_en=4'b0010, w_off++; after last beat -> L1_MAC.
REQ-008 L1_MAC (1 cycle): mac_en=2'b01; if a_idx<L1_IN -> L1_LD_A, else -> L2_LD_W with a_idx=0.
REQ-009 L2_LD_W: W2 cycles, mem_addr=ADDR_BASE_W+w_off, r_sh_en=4'b0100, w_off++; then -> L2_MAC.
REQ-010 L2_MAC (1 cycle): mac_en=2'b10, lut_sel=0, lut_pos=a_idx, mem_addr=ADDR_BASE_LUT_L1+lut_idx; a_idx++; a_idx+1<L2_IN -> L2_LD_W else -> LUT_SAVE with a_idx=0.
REQ-011 LUT_SAVE: L2_N cycles, lut_sel=1, lut_pos=a_idx, mem_addr=ADDR_BASE_LUT_L2+lut_idx, r_sh_en=4'b1000; then -> DONE.
REQ-012 DONE: done=1, held until done_ack=1, then -> IDLE; start ignored in DONE.
REQ-013 busy=1 in every state except IDLE and DONE; start while busy SHALL be ignored.
REQ-014 abort=1 in any busy state -> IDLE next cycle, no done pulse; abort in IDLE/DONE ignored; abort with start in IDLE: abort wins.
REQ-015 Outputs not listed for a state SHALL be 0; all outputs decode from registered state/counters only (Moore), except mem_addr in L2_MAC/LUT_SAVE which follows lut_idx combinationally.
REQ-016 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; counters sized by $clog2 of their limits + 1.
REQ-017 Busy cycle count without skipping SHALL be L1_IN*(W1+2) + L2_IN*(W2+1) + L2_N.

Reset
REQ-018 rst=1 at a clock edge SHALL force IDLE, zero counters/offsets; outputs then equal IDLE values (busy=0, done=0, mac_clr=2'b11, others 0), including mid-run.

Configuration
REQ-019 With NN_ZERO_SKIP_EN defined: in the first L1_LD_W cycle with arg_zero=1, r_sh_en=0, w_off+=W1, skip L1_MAC, -> L1_LD_A (or L2_LD_W if a_idx=L1_IN, a_idx=0); saves W1+... exactly W1 cycles... per skipped activation: W1 cycles saved net (beats W1 plus MAC 1, minus the 1 sampling cycle).
REQ-020 Without NN_ZERO_SKIP_EN: arg_zero ignored, timing per REQ-017.

Structure
REQ-021 Package nn_pkg SHALL hold the state enum type and the r_sh_en/mac_en bit-index localparams.
REQ-022 One sub-module nn_beat_cnt (loadable down-counter with terminal flag) SHALL serve the beat/activation counters; no other hierarchy.

Verification
REQ-023 L1_IN=4, L1_N=3, L2_N=2, LANES=2, no skip: start pulse -> busy exactly 26 cycles, done=1 until done_ack.
REQ-024 Same, NN_ZERO_SKIP_EN, arg_zero=1 for activation 2 only -> busy 24 cycles; weight addresses of activation 3 start at ADDR_BASE_W+6.
REQ-025 Abort in cycle 10 -> IDLE next cycle, done never asserted, mac_clr=2'b11.
REQ-026 rst in L2_MAC -> next cycle busy=0, counters zero; following start gives full 26-cycle run.
REQ-027 start held high during run and in DONE -> no restart until done_ack, then new run starts from IDLE.
REQ-028 lut_idx=5, ADDR_BASE_LUT_L2=100 in LUT_SAVE -> mem_addr=105, lut_sel=1, lut_pos=0 then 1.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg -- shared types and constants for the nn_layer_seq slice.
//   nn_state_t        : sequencer state encoding
//   SH_* / MAC_*      : bit positions inside r_sh_en {res,w2,w1,a} and mac_en {L2,L1}
//   max3()            : helper used to size shared counters
package nn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    L1_LD_A,
    L1_LD_W,
    L1_MAC,
    L2_LD_W,
    L2_MAC,
    LUT_SAVE,
    DONE
  } nn_state_t;

  localparam int SH_A   = 0;
  localparam int SH_W1  = 1;
  localparam int SH_W2  = 2;
  localparam int SH_RES = 3;

  localparam int MAC_L1 = 0;
  localparam int MAC_L2 = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/nn_beat_cnt.sv
// nn_beat_cnt -- loadable down-counter with terminal flag.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val (has priority over dec)
//   dec       : decrement by one, saturating at zero
//   count     : current value
//   last      : count == 0, i.e. the current beat is the final one
module nn_beat_cnt
  import nn_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/nn_layer_seq.sv
// nn_layer_seq -- two-layer neural-network inference sequencer.
// Walks layer-1 activations/weights, layer-2 weights, then saves the
// sigmoid results, driving memory addresses and datapath enables.
//   clk, rst          : clock, synchronous active-high reset
//   start, abort      : begin a run / cancel a run in progress
//   done_ack          : releases the DONE state
//   busy, done        : run active / result ready
//   mem_addr          : memory read address (wraps at 2^ADDR_WIDTH)
//   arg_zero          : currently loaded activation is zero
//   lut_idx           : sigmoid LUT index from the MAC
//   lut_pos, lut_sel  : activation/result slot, 0=L1 LUT 1=L2 LUT
//   r_sh_en           : shift enables {res,w2,w1,a}
//   mac_en, mac_clr   : MAC enable/clear {L2,L1}
// Build option: define NN_ZERO_SKIP_EN to skip the weight fetch and MAC
// for zero-valued layer-1 activations.
module nn_layer_seq
  import nn_pkg::*;
#(
  parameter int ADDR_WIDTH       = 16,
  parameter int L1_IN            = 401,
  parameter int L1_N             = 25,
  parameter int L2_N             = 10,
  parameter int LANES            = 1,
  parameter int ADDR_BASE_A      = 0,
  parameter int ADDR_BASE_W      = 0,
  parameter int ADDR_BASE_LUT_L1 = 0,
  parameter int ADDR_BASE_LUT_L2 = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  done_ack,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  arg_zero,
  input  logic [ADDR_WIDTH-1:0] lut_idx,
  output logic [ADDR_WIDTH-1:0] lut_pos,
  output logic                  lut_sel,
  output logic [3:0]            r_sh_en,
  output logic [1:0]            mac_en,
  output logic [1:0]            mac_clr
);

  localparam int W1    = (L1_N + LANES - 1) / LANES;
  localparam int W2    = (L2_N + LANES - 1) / LANES;
  localparam int L2_IN = L1_N + 1;
  localparam int IDX_W = $clog2(max3(L1_IN, L2_IN, L2_N)) + 1;
  localparam int CNT_W = $clog2(max3(W1, W2, 1)) + 1;

  nn_state_t              state;
  logic [IDX_W-1:0]       a_idx;
  logic [ADDR_WIDTH-1:0]  w_off;
  logic [CNT_W-1:0]       beat_cnt;
  logic [CNT_W-1:0]       beat_load_val;
  logic                   beat_load;
  logic                   beat_dec;
  logic                   beat_last;
  logic                   beat_first;
  logic                   skip;

  // The beat counter is loaded with W1-1 on entry to L1_LD_W, so this
  // marks the one cycle in which arg_zero is meaningful.
  assign beat_first = (beat_cnt == CNT_W'(W1 - 1));

`ifdef NN_ZERO_SKIP_EN
  assign skip = (state == L1_LD_W) && beat_first && arg_zero;
`else
  logic unused_zero_skip;
  assign skip             = 1'b0;
  assign unused_zero_skip = arg_zero ^ beat_first;
`endif

  // Reload the beat counter in every non-fetch state with the length of
  // the fetch that may follow; a skip leaving L1_LD_W may go straight to
  // L2_LD_W, so it preloads the layer-2 length (L1_LD_A overrides it).
  always_comb begin
    beat_load     = 1'b1;
    beat_load_val = '0;
    beat_dec      = 1'b0;
    case (state)
      L1_LD_A: beat_load_val = CNT_W'(W1 - 1);
      L1_LD_W: begin
        beat_load     = skip;
        beat_load_val = CNT_W'(W2 - 1);
        beat_dec      = 1'b1;
      end
      L1_MAC,
      L2_MAC:  beat_load_val = CNT_W'(W2 - 1);
      L2_LD_W: begin
        beat_load = 1'b0;
        beat_dec  = 1'b1;
      end
      default: ;
    endcase
  end

  nn_beat_cnt #(
    .WIDTH (CNT_W)
  ) u_beat (
    .clk      (clk),
    .rst      (rst),
    .load     (beat_load),
    .dec      (beat_dec),
    .load_val (beat_load_val),
    .count    (beat_cnt),
    .last     (beat_last)
  );

  // a_idx is reused: activation index in layer 1, hidden-neuron slot in
  // layer 2 and result slot in LUT_SAVE; it is cleared between phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_idx <= '0;
      w_off <= '0;
    end else if (abort && (state != IDLE) && (state != DONE)) begin
      state <= IDLE;
      a_idx <= '0;
      w_off <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state <= L1_LD_A;
            a_idx <= '0;
            w_off <= '0;
          end
        end
        L1_LD_A: begin
          a_idx <= a_idx + 1'b1;
          state <= L1_LD_W;
        end
        L1_LD_W: begin
          if (skip) begin
            w_off <= w_off + ADDR_WIDTH'(W1);
            if (a_idx == IDX_W'(L1_IN)) begin
              a_idx <= '0;
              state <= L2_LD_W;
            end else begin
              state <= L1_LD_A;
            end
          end else begin
            w_off <= w_off + 1'b1;
            if (beat_last) state <= L1_MAC;
          end
        end
        L1_MAC: begin
          if (a_idx < IDX_W'(L1_IN)) begin
            state <= L1_LD_A;
          end else begin
            a_idx <= '0;
            state <= L2_LD_W;
          end
        end
        L2_LD_W: begin
          w_off <= w_off + 1'b1;
          if (beat_last) state <= L2_MAC;
        end
        L2_MAC: begin
          if ((a_idx + 1'b1) < IDX_W'(L2_IN)) begin
            a_idx <= a_idx + 1'b1;
            state <= L2_LD_W;
          end else begin
            a_idx <= '0;
            state <= LUT_SAVE;
          end
        end
        LUT_SAVE: begin
          if (a_idx == IDX_W'(L2_N - 1)) begin
            a_idx <= '0;
            state <= DONE;
          end else begin
            a_idx <= a_idx + 1'b1;
          end
        end
        DONE: begin
          if (done_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode; only mem_addr in L2_MAC/LUT_SAVE (lut_idx) and the
  // optional skip gating of the w1 shift see inputs directly.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    mem_addr = '0;
    r_sh_en  = '0;
    mac_en   = '0;
    mac_clr  = '0;
    lut_sel  = 1'b0;
    lut_pos  = '0;
    case (state)
      IDLE: mac_clr = 2'b11;
      L1_LD_A: begin
        busy           = 1'b1;
        mem_addr       = ADDR_WIDTH'(ADDR_BASE_A) + ADDR_WIDTH'(a_idx);
        r_sh_en[SH_A]  = 1'b1;
      end
      L1_LD_W: begin
        busy           = 1'b1;
        mem_addr       = ADDR_WIDTH'(ADDR_BASE_W) + w_off;
        r_sh_en[SH_W1] = !skip;
      end
      L1_MAC: begin
        busy           = 1'b1;
        mac_en[MAC_L1] = 1'b1;
      end
      L2_LD_W: begin
        busy           = 1'b1;
        mem_addr       = ADDR_WIDTH'(ADDR_BASE_W) + w_off;
        r_sh_en[SH_W2] = 1'b1;
      end
      L2_MAC: begin
        busy           = 1'b1;
        mac_en[MAC_L2] = 1'b1;
        lut_pos        = ADDR_WIDTH'(a_idx);
        mem_addr       = ADDR_WIDTH'(ADDR_BASE_LUT_L1) + lut_idx;
      end
      LUT_SAVE: begin
        busy            = 1'b1;
        lut_sel         = 1'b1;
        lut_pos         = ADDR_WIDTH'(a_idx);
        mem_addr        = ADDR_WIDTH'(ADDR_BASE_LUT_L2) + lut_idx;
        r_sh_en[SH_RES] = 1'b1;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nn_layer_seq.sv
// tb_nn_layer_seq -- self-checking bench for nn_layer_seq.
// Small configuration L1_IN=4, L1_N=3, L2_N=2, LANES=2. Expected
// per-cycle outputs are generated as a list from the inference schedule
// (activations, weight beats, MACs, result saves) and compared cycle by
// cycle; lut_idx and don't-care arg_zero values are randomized.
// Honours NN_ZERO_SKIP_EN for the zero-activation skip expectations.
`timescale 1ns/1ps
module tb_nn_layer_seq;

  localparam int AWID  = 16;
  localparam int L1_IN = 4;
  localparam int L1_N  = 3;
  localparam int L2_N  = 2;
  localparam int LANES = 2;
  localparam int BA    = 16;
  localparam int BW    = 200;
  localparam int BL1   = 50;
  localparam int BL2   = 100;
  localparam int W1    = (L1_N + LANES - 1) / LANES;
  localparam int W2    = (L2_N + LANES - 1) / LANES;
  localparam int L2_IN = L1_N + 1;
  localparam int FULL  = L1_IN * (W1 + 2) + L2_IN * (W2 + 1) + L2_N;
`ifdef NN_ZERO_SKIP_EN
  localparam bit SKIP_BUILD = 1'b1;
`else
  localparam bit SKIP_BUILD = 1'b0;
`endif

  typedef struct {
    logic        busy;
    logic        done;
    logic [15:0] addr;
    bit          addr_lut;
    logic [3:0]  sh;
    logic [1:0]  mac_en;
    logic [1:0]  mac_clr;
    logic        sel;
    logic [15:0] pos;
    int          za;
  } exp_t;

  typedef struct {
    string      name;
    logic [3:0] zmask;
    int         abort_at;
    int         rst_at;
    bit         hold_start;
    bit         fixed_lut;
    int         exp_busy;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            done_ack = 1'b0;
  logic            busy;
  logic            done;
  logic [AWID-1:0] mem_addr;
  logic            arg_zero = 1'b0;
  logic [AWID-1:0] lut_idx = '0;
  logic [AWID-1:0] lut_pos;
  logic            lut_sel;
  logic [3:0]      r_sh_en;
  logic [1:0]      mac_en;
  logic [1:0]      mac_clr;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t idle_rec;
  exp_t done_rec;

  always #5 clk = ~clk;

  nn_layer_seq #(
    .ADDR_WIDTH       (AWID),
    .L1_IN            (L1_IN),
    .L1_N             (L1_N),
    .L2_N             (L2_N),
    .LANES            (LANES),
    .ADDR_BASE_A      (BA),
    .ADDR_BASE_W      (BW),
    .ADDR_BASE_LUT_L1 (BL1),
    .ADDR_BASE_LUT_L2 (BL2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .done_ack (done_ack),
    .busy     (busy),
    .done     (done),
    .mem_addr (mem_addr),
    .arg_zero (arg_zero),
    .lut_idx  (lut_idx),
    .lut_pos  (lut_pos),
    .lut_sel  (lut_sel),
    .r_sh_en  (r_sh_en),
    .mac_en   (mac_en),
    .mac_clr  (mac_clr)
  );

  function automatic exp_t mkRec(input logic [15:0] addr, input bit al, input logic [3:0] sh,
                                 input logic [1:0] me, input logic sel, input logic [15:0] pos,
                                 input int za);
    exp_t r;
    r.busy = 1'b1; r.done = 1'b0; r.addr = addr; r.addr_lut = al; r.sh = sh;
    r.mac_en = me; r.mac_clr = 2'b00; r.sel = sel; r.pos = pos; r.za = za;
    return r;
  endfunction

  function automatic vec_t mkVec(input string nm, input logic [3:0] zm, input int ab, input int rs,
                                 input bit hs, input bit fl, input int eb);
    vec_t v;
    v.name = nm; v.zmask = zm; v.abort_at = ab; v.rst_at = rs;
    v.hold_start = hs; v.fixed_lut = fl; v.exp_busy = eb;
    return v;
  endfunction

  // Expected cycle list of one complete run, straight from the schedule.
  task automatic buildTrace(input logic [3:0] zmask);
    int w;
    exp_q.delete();
    w = 0;
    for (int a = 0; a < L1_IN; a++) begin
      exp_q.push_back(mkRec(16'(BA + a), 1'b0, 4'b0001, 2'b00, 1'b0, 16'd0, a));
      if (SKIP_BUILD && zmask[a]) begin
        exp_q.push_back(mkRec(16'(BW + w), 1'b0, 4'b0000, 2'b00, 1'b0, 16'd0, a));
        w += W1;
      end else begin
        for (int b = 0; b < W1; b++) begin
          exp_q.push_back(mkRec(16'(BW + w), 1'b0, 4'b0010, 2'b00, 1'b0, 16'd0, a));
          w++;
        end
        exp_q.push_back(mkRec(16'd0, 1'b0, 4'b0000, 2'b01, 1'b0, 16'd0, a));
      end
    end
    for (int j = 0; j < L2_IN; j++) begin
      for (int b = 0; b < W2; b++) begin
        exp_q.push_back(mkRec(16'(BW + w), 1'b0, 4'b0100, 2'b00, 1'b0, 16'd0, -1));
        w++;
      end
      exp_q.push_back(mkRec(16'(BL1), 1'b1, 4'b0000, 2'b10, 1'b0, 16'(j), -1));
    end
    for (int k = 0; k < L2_N; k++)
      exp_q.push_back(mkRec(16'(BL2), 1'b1, 4'b1000, 2'b00, 1'b1, 16'(k), -1));
  endtask

  task automatic applyStimulus(input logic s, input logic ab, input logic ack, input logic az,
                               input logic [15:0] li);
    start    = s;
    abort    = ab;
    done_ack = ack;
    arg_zero = az;
    lut_idx  = li;
  endtask

  task automatic checkOutput(input string nm, input exp_t r);
    logic [42:0] got, want;
    logic [15:0] ea;
    ea   = r.addr_lut ? 16'(r.addr + lut_idx) : r.addr;
    want = {r.busy, r.done, ea, r.sh, r.mac_en, r.mac_clr, r.sel, r.pos};
    got  = {busy, done, mem_addr, r_sh_en, mac_en, mac_clr, lut_sel, lut_pos};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got busy=%b done=%b addr=%0d sh=%b mac_en=%b mac_clr=%b sel=%b pos=%0d, expected busy=%b done=%b addr=%0d sh=%b mac_en=%b mac_clr=%b sel=%b pos=%0d",
               nm, busy, done, mem_addr, r_sh_en, mac_en, mac_clr, lut_sel, lut_pos,
               r.busy, r.done, ea, r.sh, r.mac_en, r.mac_clr, r.sel, r.pos);
    end
  endtask

  task automatic checkInt(input string nm, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  // Runs one table vector; entered and left at a falling edge with the DUT idle.
  task automatic runScenario(input vec_t v);
    exp_t r;
    int   idx, busy_cnt, guard;
    bit   cut, cut_now;
    logic az;
    buildTrace(v.zmask);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'($urandom), 16'($urandom));
    @(negedge clk);
    idx = 0; busy_cnt = 0; cut = 1'b0;
    while (exp_q.size() > 0) begin
      r  = exp_q.pop_front();
      az = (SKIP_BUILD && r.za >= 0) ? v.zmask[r.za] : 1'($urandom);
      cut_now = (idx == v.abort_at) || (idx == v.rst_at);
      applyStimulus(v.hold_start, idx == v.abort_at, 1'b0, az,
                    v.fixed_lut ? 16'd5 : 16'($urandom));
      rst = (idx == v.rst_at);
      #1;
      if (busy === 1'b1) busy_cnt++;
      checkOutput($sformatf("%s[%0d]", v.name, idx), r);
      @(negedge clk);
      idx++;
      if (cut_now) begin
        cut = 1'b1;
        break;
      end
    end
    rst = 1'b0;
    applyStimulus(v.hold_start, 1'b0, 1'b0, 1'($urandom), 16'($urandom));
    #1;
    guard = 0;
    while (busy === 1'b1 && guard < 64) begin
      busy_cnt++; guard++;
      @(negedge clk); #1;
    end
    checkInt({v.name, "_busy_len"}, busy_cnt, v.exp_busy);
    if (cut) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("%s_idle%0d", v.name, k), idle_rec);
        @(negedge clk); lut_idx = 16'($urandom); #1;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("%s_done%0d", v.name, k), done_rec);
        @(negedge clk); lut_idx = 16'($urandom); #1;
      end
      done_ack = 1'b1;
      @(negedge clk);
      done_ack = 1'b0;
      #1;
      checkOutput({v.name, "_ack_idle"}, idle_rec);
      if (v.hold_start) begin
        @(negedge clk); #1;
        checkOutput({v.name, "_restart"}, mkRec(16'(BA), 1'b0, 4'b0001, 2'b00, 1'b0, 16'd0, 0));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        checkOutput({v.name, "_abort_idle"}, idle_rec);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        @(negedge clk); #1;
        checkOutput({v.name, "_abort_beats_start"}, idle_rec);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t       vecs[10];
    logic [3:0] rm;

    idle_rec = mkRec(16'd0, 1'b0, 4'b0000, 2'b00, 1'b0, 16'd0, -1);
    idle_rec.busy = 1'b0; idle_rec.mac_clr = 2'b11;
    done_rec = idle_rec;
    done_rec.done = 1'b1; done_rec.mac_clr = 2'b00;

    rm = 4'($urandom);
    vecs[0] = mkVec("basic",      4'b0000, -1, -1, 1'b0, 1'b0, 26);
    vecs[1] = mkVec("skip_act2",  4'b0100, -1, -1, 1'b0, 1'b0, SKIP_BUILD ? 24 : 26);
    vecs[2] = mkVec("lut5",       4'b0000, -1, -1, 1'b0, 1'b1, 26);
    vecs[3] = mkVec("abort10",    4'b0000, 10, -1, 1'b0, 1'b0, 11);
    vecs[4] = mkVec("rst_l2mac",  4'b0000, -1, 17, 1'b0, 1'b0, 18);
    vecs[5] = mkVec("after_rst",  4'b0000, -1, -1, 1'b0, 1'b0, 26);
    vecs[6] = mkVec("hold_start", 4'b0000, -1, -1, 1'b1, 1'b0, 26);
    vecs[7] = mkVec("skip_edges", 4'b1001, -1, -1, 1'b0, 1'b0, SKIP_BUILD ? 22 : 26);
    vecs[8] = mkVec("skip_all",   4'b1111, -1, -1, 1'b0, 1'b0, SKIP_BUILD ? 18 : 26);
    vecs[9] = mkVec("rand_mask",  rm,      -1, -1, 1'b0, 1'b0,
                    FULL - (SKIP_BUILD ? W1 * $countones(rm) : 0));

    repeat (3) @(negedge clk);
    #1;
    checkOutput("in_reset", idle_rec);
    rst = 1'b0;
    @(negedge clk); #1;
    checkOutput("after_reset", idle_rec);
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      $display("[TB] vector %s zmask=%b", vecs[i].name, vecs[i].zmask);
      runScenario(vecs[i]);
    end

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    @(negedge clk); #1;
    checkOutput("idle_ignores_abort", idle_rec);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
